// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg
// Shared definitions for the round-robin interval scheduler:
//   - default requester count and counter width
//   - FSM state encoding
//   - helper to size an index into the requester vector
package counter_sched_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_CW   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Width of an index into an n-entry vector (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_sched_counter.sv
// counter_sched_counter
// Free-running up-counter shared by all requesters of counter_sched.
// Ports:
//   clk     - clock, rising edge
//   srst_i  - synchronous clear (system reset or scheduler clear), wins over en_i
//   en_i    - advance the count by one this cycle
//   count_o - current count, wraps modulo 2^CW
module counter_sched_counter
    import counter_sched_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          srst_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_sched.sv
// counter_sched
// Round-robin scheduler that lends one shared interval counter to NREQ
// requesters. The owner is granted for one LOAD cycle plus len cycles of
// RUN (len 0 means 2^CW cycles), then receives a one-cycle done pulse.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   req       - per-requester level request, held until done or abort
//   len       - per-requester interval length, slice i = len[i*CW +: CW]
//   grant     - one-hot owner during LOAD/RUN, zero otherwise
//   done      - one-cycle one-hot pulse at interval completion
//   busy      - high whenever the FSM is not IDLE
//   cur_count - shared counter value
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CW   = DEF_CW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [CW-1:0]      cur_count
);

    localparam int OW = idx_width(NREQ);

    state_e         state_q, state_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [OW-1:0]  last_q, last_d;
    logic [CW-1:0]  len_q, len_d;

    logic [CW-1:0]  len_arr [NREQ];
    logic [NREQ-1:0] owner_oh;
    logic [NREQ-1:0] above_last;
    logic [NREQ-1:0] req_above;
    logic [OW-1:0]  pick_lo, pick_hi, pick;
    logic           req_owner;
    logic           cnt_en;
    logic           cnt_clr;
    logic           cnt_srst;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign len_arr[gi]    = len[gi*CW +: CW];
            assign owner_oh[gi]   = (owner_q == OW'(gi));
            assign above_last[gi] = (OW'(gi) > last_q);
        end
    endgenerate

    assign req_above = req & above_last;
    assign req_owner = |(req & owner_oh);

    // Round-robin: lowest requester above last_owner wins; if none, wrap
    // around to the lowest requester overall.
    always_comb begin : rr_pick
        pick_lo = '0;
        pick_hi = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_lo = OW'(i);
            end
            if (req_above[i]) begin
                pick_hi = OW'(i);
            end
        end
        pick = (|req_above) ? pick_hi : pick_lo;
    end

    always_comb begin : fsm_next
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        len_d   = len_q;
        cnt_en  = 1'b0;
        grant   = '0;
        done    = '0;
        busy    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (|req) begin
                    owner_d = pick;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                grant = owner_oh;
                len_d = len_arr[owner_q];
                if (!req_owner) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                grant  = owner_oh;
                cnt_en = 1'b1;
                if (!req_owner) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else if (cur_count == len_q - CW'(1)) begin
                    // len 0 compares against all-ones: a full 2^CW run.
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = owner_oh;
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clearing on the state being entered keeps the counter at zero for
    // every IDLE cycle, including the first one after DONE or an abort.
    assign cnt_clr  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    assign cnt_srst = rst || cnt_clr;

    counter_sched_counter #(
        .CW (CW)
    ) u_counter (
        .clk     (clk),
        .srst_i  (cnt_srst),
        .en_i    (cnt_en),
        .count_o (cur_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            len_q   <= len_d;
        end
    end

endmodule
